pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- The forwarding network covers EX/MEM and MEM/WB dependencies. This block handles the hazards forwarding cannot cover:
  - load-use stalls;
  - taken-branch flushes;
  - multi-cycle multiply/divide occupancy of EX;
  - halt drain.
- It drives the enable and flush controls of the PC and of the IF/ID, ID/EX and EX/MEM pipeline registers. It also keeps a saturating stall-cycle counter for performance reporting.

Parameters:
- MUL_LAT, 4: cycles the EX stage is occupied by a multiply (must be ≥2).
- DIV_LAT, 32: cycles the EX stage is occupied by a divide (must be ≥2).
- DRAIN, 3: cycles allowed after halt enters ID for older instructions to retire.
- CNT_W, 32: width of stall_cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- reg_rs_ID  in  5  rs field of the instruction in ID.
- reg_rt_ID  in  5  rt field of the instruction in ID.
- uses_rs_ID  in  1  ID instruction reads rs.
- uses_rt_ID  in  1  ID instruction reads rt.
- halt_ID  in  1  ID instruction is halt.
- mem_read_EX  in  1  EX instruction is a load.
- reg_dest_EX  in  5  destination register of the EX instruction.
- branch_taken_EX  in  1  EX branch resolved taken.
- md_start_EX  in  1  EX instruction is mul/div.
- md_is_div_EX  in  1  1 = divide, 0 = multiply.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clear to nop.
- id_ex_en  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX clear to nop (bubble).
- ex_mem_flush  out  1  EX/MEM clear to nop.
- md_done  out  1  pulse on the last multiply/divide cycle.
- halted  out  1  pipeline drained and stopped.
- stall_cycles  out  CNT_W  saturating count of stall cycles.

Behaviour:
- States: RUN, MD_BUSY, DRAIN_S, HALTED. State is registered; all control outputs are combinational from the state and the inputs.
- Reset while rst=1:
  - state = RUN; md counter = 0; stall_cycles = 0; halted = 0; md_done = 0.
  - pc_en = if_id_en = id_ex_en = 0.
  - if_id_flush = id_ex_flush = ex_mem_flush = 1.
  - Reset asserted mid-operation abandons any busy or drain state immediately.
- Defaults in RUN: all enables 1, all flushes 0.
- RUN priority, highest first:
  1. branch_taken_EX: if_id_flush = 1 and id_ex_flush = 1; pc_en stays 1 to load the target. Any load-use stall, halt_ID or md_start_EX in the same cycle is ignored. Stay in RUN.
  2. md_start_EX:
     - pc_en = if_id_en = id_ex_en = 0; ex_mem_flush = 1.
     - Load counter with (md_is_div_EX ? DIV_LAT : MUL_LAT) − 2 and go to MD_BUSY.
  3. Load-use: mem_read_EX, reg_dest_EX ≠ 0, and ((uses_rs_ID and reg_rs_ID = reg_dest_EX) or (uses_rt_ID and reg_rt_ID = reg_dest_EX)).
     - pc_en = 0; if_id_en = 0; id_ex_flush = 1.
     - Exactly one bubble; stay in RUN. Next cycle the load is in MEM and forwarding supplies the data.
  4. halt_ID: pc_en = 0; if_id_en = 0; id_ex_flush = 1; counter = DRAIN − 1; go to DRAIN_S.
- MD_BUSY:
  - pc_en = if_id_en = id_ex_en = 0; ex_mem_flush = 1.
  - Counter decrements each cycle.
  - When counter = 0: md_done = 1, all enables 1, ex_mem_flush = 0, and go to RUN.
  - Total occupancy is exactly LAT cycles, including the start cycle.
  - md_start_EX and branch_taken_EX are ignored while in MD_BUSY.
- DRAIN_S:
  - pc_en = if_id_en = 0; id_ex_flush = 1.
  - Counter decrements; when counter = 0, go to HALTED.
- HALTED:
  - halted = 1; all enables 0; all flushes 1.
  - Exit only through rst.
- stall_cycles:
  - Increments on every clock edge where pc_en = 0 and state ≠ HALTED.
  - Saturates at all-ones and never wraps.

Decomposition:
- Shared constants.v additions:
  - `PC_RUN, `PC_MD_BUSY, `PC_DRAIN, `PC_HALTED as 2-bit state encodings.
  - `REG_ZERO = 5'd0.
- One sub-module, load_use_detect: the combinational compare behind the load-use condition, with output stall_lu.
- The state machine, counters and output decode live in pipeline_ctrl.

Test Plan:
- Load-use: mem_read_EX = 1, reg_dest_EX = 8, uses_rs_ID = 1, reg_rs_ID = 8 → for one cycle pc_en = 0, if_id_en = 0, id_ex_flush = 1; the next cycle all enables are 1; stall_cycles = 1.
- No false stall on r0 or an unused operand: reg_dest_EX = 0 with rs = 0, or uses_rt_ID = 0 with rt match → no stall.
- Branch beats load-use: branch_taken_EX = 1 together with a load-use match → if_id_flush = id_ex_flush = 1, pc_en = 1, no stall counted.
- Divide: md_start_EX = 1, md_is_div_EX = 1 (DIV_LAT = 32) → pc_en low for 31 cycles; md_done pulses in cycle 32 with enables high; stall_cycles = 31. Repeat with multiply → 3 stall cycles, md_done in cycle 4.
- Halt: halt_ID = 1 → after DRAIN = 3 cycles halted = 1 and stays high for 100 cycles; asserting rst asynchronously mid-drain → halted = 0 and state = RUN.
- Saturation: CNT_W = 4 with 20 stall cycles → stall_cycles holds at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer:
//   - pc_state_e : 2-bit sequencer state encodings (RUN, MD_BUSY, DRAIN, HALTED)
//   - REG_ZERO   : architectural zero register index
//   - ctrl_t     : bundle of the control outputs
//   - CTRL_*     : control bundles for each pipeline situation
//   - max_int()  : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN     = 2'd0,
    PC_MD_BUSY = 2'd1,
    PC_DRAIN   = 2'd2,
    PC_HALTED  = 2'd3
  } pc_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic md_done;
    logic halted;
  } ctrl_t;

  // Normal flow: everything advances, nothing is squashed.
  localparam ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b0, ex_mem_flush: 1'b0, md_done: 1'b0, halted: 1'b0};

  // Taken branch: squash the two younger instructions, PC loads the target.
  localparam ctrl_t CTRL_FLUSH = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
    id_ex_flush: 1'b1, ex_mem_flush: 1'b0, md_done: 1'b0, halted: 1'b0};

  // Hold PC and IF/ID, insert a bubble into EX (load-use, halt, drain).
  localparam ctrl_t CTRL_BUBBLE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b1, ex_mem_flush: 1'b0, md_done: 1'b0, halted: 1'b0};

  // Multiply/divide owns EX: freeze the front end, feed nops into MEM.
  localparam ctrl_t CTRL_MD_STALL = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
    id_ex_flush: 1'b0, ex_mem_flush: 1'b1, md_done: 1'b0, halted: 1'b0};

  // Final multiply/divide cycle: result leaves EX, the pipeline resumes.
  localparam ctrl_t CTRL_MD_DONE = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b0, ex_mem_flush: 1'b0, md_done: 1'b1, halted: 1'b0};

  localparam ctrl_t CTRL_HALTED = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1, id_ex_en: 1'b0,
    id_ex_flush: 1'b1, ex_mem_flush: 1'b1, md_done: 1'b0, halted: 1'b1};

  localparam ctrl_t CTRL_RESET = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1, id_ex_en: 1'b0,
    id_ex_flush: 1'b1, ex_mem_flush: 1'b1, md_done: 1'b0, halted: 1'b0};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
// Hazard inputs from the ID/EX stages and the enable/flush controls returned
// to the pipeline registers.
//   master : the pipeline datapath (drives hazard info, consumes controls)
//   slave  : pipeline_ctrl (consumes hazard info, drives controls)
// Parameter CNT_W sets the width of the stall_cycles performance counter.
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);

  // Hazard information
  logic [4:0]       reg_rs_ID;
  logic [4:0]       reg_rt_ID;
  logic             uses_rs_ID;
  logic             uses_rt_ID;
  logic             halt_ID;
  logic             mem_read_EX;
  logic [4:0]       reg_dest_EX;
  logic             branch_taken_EX;
  logic             md_start_EX;
  logic             md_is_div_EX;

  // Pipeline controls and status
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             md_done;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output reg_rs_ID, reg_rt_ID, uses_rs_ID, uses_rt_ID, halt_ID,
           mem_read_EX, reg_dest_EX, branch_taken_EX, md_start_EX, md_is_div_EX,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush,
           md_done, halted, stall_cycles
  );

  modport slave (
    input  reg_rs_ID, reg_rt_ID, uses_rs_ID, uses_rt_ID, halt_ID,
           mem_read_EX, reg_dest_EX, branch_taken_EX, md_start_EX, md_is_div_EX,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush,
           md_done, halted, stall_cycles
  );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Flags an instruction in ID that needs the result of a load still in EX.
// That value only exists after MEM, so forwarding cannot help and one bubble
// is required.
//   reg_rs_ID / reg_rt_ID    : source fields of the ID instruction
//   uses_rs_ID / uses_rt_ID  : which of those fields are actually read
//   mem_read_EX, reg_dest_EX : the EX instruction is a load into reg_dest_EX
//   stall_lu                 : load-use hazard present
// -----------------------------------------------------------------------------
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] reg_rs_ID,
  input  logic [4:0] reg_rt_ID,
  input  logic       uses_rs_ID,
  input  logic       uses_rt_ID,
  input  logic       mem_read_EX,
  input  logic [4:0] reg_dest_EX,
  output logic       stall_lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = uses_rs_ID && (reg_rs_ID == reg_dest_EX);
  assign rt_hit = uses_rt_ID && (reg_rt_ID == reg_dest_EX);

  // A load into r0 is discarded, so nothing can depend on it.
  assign stall_lu = mem_read_EX && (reg_dest_EX != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Stall/flush sequencer for the 5-stage pipeline. Covers the hazards the
// forwarding network cannot: load-use stalls, taken-branch flushes,
// multi-cycle multiply/divide occupancy of EX, and the halt drain. Also keeps
// a saturating count of stall cycles.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : pipeline_ctrl_if.slave (hazard inputs, enable/flush outputs,
//          md_done, halted, stall_cycles)
// Parameters:
//   MUL_LAT / DIV_LAT : total EX occupancy of a multiply / divide (>= 2)
//   DRAIN             : cycles granted to older instructions after halt in ID
//   CNT_W             : stall_cycles width (must match the interface)
// -----------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int DRAIN   = 3,
  parameter int CNT_W   = 32
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  // One shared down-counter serves both the multi-cycle op and the drain.
  localparam int MAX_LOAD = max_int(max_int(MUL_LAT - 2, DIV_LAT - 2), DRAIN - 1);
  localparam int CTR_W    = max_int($clog2(MAX_LOAD + 1), 1);

  localparam logic [CTR_W-1:0] MUL_LOAD   = CTR_W'(MUL_LAT - 2);
  localparam logic [CTR_W-1:0] DIV_LOAD   = CTR_W'(DIV_LAT - 2);
  localparam logic [CTR_W-1:0] DRAIN_LOAD = CTR_W'(DRAIN - 1);

  pc_state_e        state_q;
  pc_state_e        state_d;
  logic [CTR_W-1:0] ctr_q;
  logic [CTR_W-1:0] ctr_d;
  logic [CNT_W-1:0] stall_q;
  logic             stall_lu;
  ctrl_t            ctrl;

  load_use_detect u_load_use_detect (
    .reg_rs_ID   (bus.reg_rs_ID),
    .reg_rt_ID   (bus.reg_rt_ID),
    .uses_rs_ID  (bus.uses_rs_ID),
    .uses_rt_ID  (bus.uses_rt_ID),
    .mem_read_EX (bus.mem_read_EX),
    .reg_dest_EX (bus.reg_dest_EX),
    .stall_lu    (stall_lu)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: registered state uses non-blocking assignments so every flop samples
  // its inputs as they were before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PC_RUN;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    case (state_q)
      PC_RUN: begin
        // A taken branch squashes the ID instruction, so whatever it asked
        // for (halt, load-use) is moot, and the EX mul/div was mispredicted.
        if (!bus.branch_taken_EX) begin
          if (bus.md_start_EX) begin
            ctr_d   = bus.md_is_div_EX ? DIV_LOAD : MUL_LOAD;
            state_d = PC_MD_BUSY;
          end else if (!stall_lu && bus.halt_ID) begin
            ctr_d   = DRAIN_LOAD;
            state_d = PC_DRAIN;
          end
        end
      end
      PC_MD_BUSY: begin
        if (ctr_q == '0) state_d = PC_RUN;
        else             ctr_d   = ctr_q - 1'b1;
      end
      PC_DRAIN: begin
        if (ctr_q == '0) state_d = PC_HALTED;
        else             ctr_d   = ctr_q - 1'b1;
      end
      PC_HALTED: begin
        state_d = PC_HALTED;
      end
      default: begin
        state_d = PC_RUN;
        ctr_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (combinational from state and inputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl = CTRL_RUN;
    case (state_q)
      PC_RUN: begin
        if (bus.branch_taken_EX)  ctrl = CTRL_FLUSH;
        else if (bus.md_start_EX) ctrl = CTRL_MD_STALL;
        else if (stall_lu)        ctrl = CTRL_BUBBLE;
        else if (bus.halt_ID)     ctrl = CTRL_BUBBLE;
      end
      PC_MD_BUSY: ctrl = (ctr_q == '0) ? CTRL_MD_DONE : CTRL_MD_STALL;
      PC_DRAIN:   ctrl = CTRL_BUBBLE;
      PC_HALTED:  ctrl = CTRL_HALTED;
      default:    ctrl = CTRL_RESET;
    endcase
    // Reset must quiesce the pipeline immediately, not at the next edge.
    if (rst) ctrl = CTRL_RESET;
  end

  assign bus.pc_en        = ctrl.pc_en;
  assign bus.if_id_en     = ctrl.if_id_en;
  assign bus.if_id_flush  = ctrl.if_id_flush;
  assign bus.id_ex_en     = ctrl.id_ex_en;
  assign bus.id_ex_flush  = ctrl.id_ex_flush;
  assign bus.ex_mem_flush = ctrl.ex_mem_flush;
  assign bus.md_done      = ctrl.md_done;
  assign bus.halted       = ctrl.halted;

  // ---------------------------------------------------------------------------
  // Stall-cycle counter: a cycle is a stall when the PC is held outside of the
  // halted state. Saturates rather than wrapping so the figure stays a bound.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!ctrl.pc_en && (state_q != PC_HALTED) && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Scoreboard bench for pipeline_ctrl. The driver applies one stimulus per
// cycle, predicts the outputs from a behavioural model (remaining busy/drain
// cycles and a running stall total) and queues them; a monitor on the falling
// edge pops and compares. A second instance with CNT_W = 4 shares the inputs
// so counter saturation is checked against the same model.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam int DRAIN   = 3;

  // Expected control bits, ordered
  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush, md_done, halted}
  localparam logic [7:0] CTL_RUN    = 8'b1101_0000;
  localparam logic [7:0] CTL_FLUSH  = 8'b1111_1000;
  localparam logic [7:0] CTL_BUBBLE = 8'b0001_1000;
  localparam logic [7:0] CTL_MD     = 8'b0000_0100;
  localparam logic [7:0] CTL_DONE   = 8'b1101_0010;
  localparam logic [7:0] CTL_HALTED = 8'b0010_1101;
  localparam logic [7:0] CTL_RESET  = 8'b0010_1100;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       halt;
    logic       mrd;
    logic [4:0] dest;
    logic       br;
    logic       mds;
    logic       mdd;
  } stim_t;

  typedef struct packed {
    logic [7:0]  ctl;
    logic [31:0] stall;
    logic [3:0]  stall_sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(32)) bus ();
  pipeline_ctrl_if #(.CNT_W(4))  bus_sat ();

  assign bus_sat.reg_rs_ID       = bus.reg_rs_ID;
  assign bus_sat.reg_rt_ID       = bus.reg_rt_ID;
  assign bus_sat.uses_rs_ID      = bus.uses_rs_ID;
  assign bus_sat.uses_rt_ID      = bus.uses_rt_ID;
  assign bus_sat.halt_ID         = bus.halt_ID;
  assign bus_sat.mem_read_EX     = bus.mem_read_EX;
  assign bus_sat.reg_dest_EX     = bus.reg_dest_EX;
  assign bus_sat.branch_taken_EX = bus.branch_taken_EX;
  assign bus_sat.md_start_EX     = bus.md_start_EX;
  assign bus_sat.md_is_div_EX    = bus.md_is_div_EX;

  pipeline_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .DRAIN(DRAIN), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipeline_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .DRAIN(DRAIN), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_sat)
  );

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: how many more cycles EX stays busy, how many drain cycles
  // remain, whether the core is halted, and the total of stalled cycles.
  // ---------------------------------------------------------------------------
  int          md_left    = 0;
  int          drain_left = 0;
  bit          is_halted  = 0;
  longint      stall_cnt  = 0;

  function automatic bit load_use(input stim_t s);
    return s.mrd && (s.dest != 5'd0) &&
           ((s.urs && s.rs == s.dest) || (s.urt && s.rt == s.dest));
  endfunction

  task automatic apply(input stim_t s);
    exp_t       e;
    logic [7:0] ctl;
    bit         was_halted;
    @(posedge clk);
    #1;
    rst                 = s.rst;
    bus.reg_rs_ID       = s.rs;
    bus.reg_rt_ID       = s.rt;
    bus.uses_rs_ID      = s.urs;
    bus.uses_rt_ID      = s.urt;
    bus.halt_ID         = s.halt;
    bus.mem_read_EX     = s.mrd;
    bus.reg_dest_EX     = s.dest;
    bus.branch_taken_EX = s.br;
    bus.md_start_EX     = s.mds;
    bus.md_is_div_EX    = s.mdd;

    was_halted = is_halted;
    if (s.rst) begin
      md_left = 0; drain_left = 0; is_halted = 0; stall_cnt = 0;
      ctl = CTL_RESET;
    end else if (is_halted) begin
      ctl = CTL_HALTED;
    end else if (md_left > 0) begin
      ctl = (md_left == 1) ? CTL_DONE : CTL_MD;
      md_left--;
    end else if (drain_left > 0) begin
      ctl = CTL_BUBBLE;
      drain_left--;
      if (drain_left == 0) is_halted = 1;
    end else if (s.br) begin
      ctl = CTL_FLUSH;
    end else if (s.mds) begin
      ctl = CTL_MD;
      md_left = (s.mdd ? DIV_LAT : MUL_LAT) - 1;
    end else if (load_use(s)) begin
      ctl = CTL_BUBBLE;
    end else if (s.halt) begin
      ctl = CTL_BUBBLE;
      drain_left = DRAIN;
    end else begin
      ctl = CTL_RUN;
    end

    e.ctl       = ctl;
    e.stall     = 32'(stall_cnt);
    e.stall_sat = (stall_cnt > 15) ? 4'd15 : 4'(stall_cnt);
    exp_q.push_back(e);

    if (!s.rst && !ctl[7] && !was_halted && stall_cnt < 64'hFFFF_FFFF) stall_cnt++;
  endtask

  function automatic stim_t idle_stim();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t reset_stim();
    stim_t s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim(input bit allow_halt);
    stim_t s;
    s.rst  = 1'b0;
    s.rs   = 5'($urandom_range(0, 3));
    s.rt   = 5'($urandom_range(0, 3));
    s.urs  = 1'($urandom_range(0, 1));
    s.urt  = 1'($urandom_range(0, 1));
    s.mrd  = 1'($urandom_range(0, 1));
    s.dest = 5'($urandom_range(0, 3));
    s.br   = ($urandom_range(0, 7) == 0);
    s.mds  = ($urandom_range(0, 15) == 0);
    s.mdd  = ($urandom_range(0, 3) == 0);
    s.halt = allow_halt && ($urandom_range(0, 49) == 0);
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ctrl", 64'({bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
                         bus.id_ex_flush, bus.ex_mem_flush, bus.md_done, bus.halted}),
            64'(e.ctl));
      check("stall_cycles", 64'(bus.stall_cycles), 64'(e.stall));
      check("stall_cycles_sat", 64'(bus_sat.stall_cycles), 64'(e.stall_sat));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    stim_t s;
    int    halted_for;

    bus.reg_rs_ID = '0; bus.reg_rt_ID = '0; bus.uses_rs_ID = 0; bus.uses_rt_ID = 0;
    bus.halt_ID = 0; bus.mem_read_EX = 0; bus.reg_dest_EX = '0;
    bus.branch_taken_EX = 0; bus.md_start_EX = 0; bus.md_is_div_EX = 0;

    apply(reset_stim());
    apply(reset_stim());
    apply(idle_stim());

    // Load-use on rs: one bubble, then normal flow.
    s = idle_stim(); s.mrd = 1; s.dest = 5'd8; s.urs = 1; s.rs = 5'd8;
    apply(s);
    apply(idle_stim());

    // No stall for a load into r0, nor for an rt match that is not read.
    s = idle_stim(); s.mrd = 1; s.dest = 5'd0; s.urs = 1; s.rs = 5'd0;
    apply(s);
    s = idle_stim(); s.mrd = 1; s.dest = 5'd9; s.urt = 0; s.rt = 5'd9;
    apply(s);
    // rt match that is read does stall.
    s.urt = 1;
    apply(s);

    // Branch beats load-use and halt.
    s = idle_stim(); s.br = 1; s.mrd = 1; s.dest = 5'd8; s.urs = 1; s.rs = 5'd8; s.halt = 1;
    apply(s);
    apply(idle_stim());

    // Divide with noisy inputs during the busy window, then multiply.
    s = idle_stim(); s.mds = 1; s.mdd = 1;
    apply(s);
    for (int i = 0; i < DIV_LAT + 2; i++) apply(rand_stim(0));
    while (md_left > 0) apply(idle_stim());
    s = idle_stim(); s.mds = 1; s.mdd = 0;
    apply(s);
    for (int i = 0; i < MUL_LAT + 1; i++) apply(idle_stim());

    // Halt drain and a long halted stretch.
    s = idle_stim(); s.halt = 1;
    apply(s);
    for (int i = 0; i < DRAIN + 100; i++) apply(rand_stim(1));

    // Reset while draining.
    apply(reset_stim());
    apply(idle_stim());
    s = idle_stim(); s.halt = 1;
    apply(s);
    apply(idle_stim());
    apply(reset_stim());
    apply(idle_stim());
    apply(idle_stim());

    // Randomised run with occasional resets to leave the halted state.
    halted_for = 0;
    for (int i = 0; i < 1500; i++) begin
      if (is_halted) halted_for++;
      else           halted_for = 0;
      if (halted_for > 8 || $urandom_range(0, 199) == 0) apply(reset_stim());
      else                                              apply(rand_stim(1));
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
